multi_edge_pulser: RTL

MULTI_EDGE_PULSER -- requirements
Module: multi_edge_pulser

---
 rtl/edge_pulser_pkg.sv | 27 ++
 rtl/edge_pulser_ch.sv | 98 +++++++++
 rtl/multi_edge_pulser.sv | 39 +++
 3 files changed

// File: rtl/edge_pulser_pkg.sv
// Shared constants for the multi-channel edge pulser: FSM state encoding, edge-mode codes
// and the edge/mode qualification helper.
package edge_pulser_pkg;

    localparam logic [1:0] LOW    = 2'b00;
    localparam logic [1:0] HIGH   = 2'b01;
    localparam logic [1:0] REPEAT = 2'b10;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    localparam int CNT_W   = 8;
    localparam int TIMER_W = 16;

    // True when a level flip in the given direction should raise a pulse.
    function automatic logic edge_match(input logic [1:0] mode, input logic rising);
        case (mode)
            MODE_RISE: return rising;
            MODE_FALL: return !rising;
            MODE_BOTH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_pulser_ch.sv
// One channel: two-flop synchroniser, debounce counter, LOW/HIGH/REPEAT state machine and
// registered pulse. Auto-repeat exists only when MULTI_EDGE_PULSER_REPEAT_EN is defined.
module edge_pulser_ch
    import edge_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 100,
    parameter int REPEAT_PERIOD   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic [1:0] mode,
    input  logic       en,
    output logic       level,
    output logic       pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg, sync2_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             pulse_reg, pulse_next;
    logic [1:0]       state_reg, state_next;
    logic             flip, edge_hit;

`ifdef MULTI_EDGE_PULSER_REPEAT_EN
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               rep_hit;
`endif

    always_comb begin
        flip       = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);
        edge_hit   = flip && en && edge_match(mode, !level_reg);
        level_next = level_reg ^ flip;
        cnt_next   = (sync2_reg == level_reg || flip) ? '0 : cnt_reg + 1'b1;
        state_next = state_reg;
        if (flip) begin
            state_next = level_reg ? LOW : HIGH;
        end
`ifdef MULTI_EDGE_PULSER_REPEAT_EN
        // Timer runs only while repeats are allowed; any flip or disable restarts it.
        timer_next = '0;
        rep_hit    = 1'b0;
        if (!flip && en && (mode == MODE_RISE || mode == MODE_BOTH)) begin
            if (state_reg == HIGH) begin
                if (timer_reg == DELAY_LAST) begin
                    rep_hit    = 1'b1;
                    state_next = REPEAT;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end else if (state_reg == REPEAT) begin
                if (timer_reg == PERIOD_LAST) begin
                    rep_hit = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
        end
        pulse_next = edge_hit | rep_hit;
`else
        pulse_next = edge_hit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            state_reg <= LOW;
`ifdef MULTI_EDGE_PULSER_REPEAT_EN
            timer_reg <= '0;
`endif
        end else begin
            sync1_reg <= in;
            sync2_reg <= sync1_reg;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            pulse_reg <= pulse_next;
            state_reg <= state_next;
`ifdef MULTI_EDGE_PULSER_REPEAT_EN
            timer_reg <= timer_next;
`endif
        end
    end

    assign level = level_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/multi_edge_pulser.sv
// WIDTH independent debounced edge-pulse channels plus an any-pulse summary.
// Optional auto-repeat of held-high channels: define MULTI_EDGE_PULSER_REPEAT_EN.
module multi_edge_pulser
    import edge_pulser_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 100,
    parameter int REPEAT_PERIOD   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic             any_pulse
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        edge_pulser_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .in    (in[gi]),
            .mode  (mode),
            .en    (en),
            .level (level[gi]),
            .pulse (pulse[gi])
        );
    end

    assign any_pulse = |pulse;

endmodule
